// File: rtl/irq_conditioner.sv
// Interrupt front-end: per-line polarity, synchroniser, debounce filter and level/edge output.
// Optional rejected-glitch counter is built only when IRQ_GLITCH_CNT_EN is defined.
module irq_conditioner #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DB_BITS     = 4
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [WIDTH-1:0]   irq_raw_i,
    input  logic [WIDTH-1:0]   polarity_i,
    input  logic [WIDTH-1:0]   edge_mode_i,
    input  logic [DB_BITS-1:0] debounce_len_i,
    output logic [WIDTH-1:0]   irq_o,
    output logic [WIDTH-1:0]   stable_o,
    output logic [7:0]         glitch_cnt_o,
    input  logic               glitch_cnt_clr_i
);

    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [DB_BITS-1:0] CNT_ONE = DB_BITS'(1);

    logic [WIDTH-1:0]   sync_q [STAGES];
    logic [WIDTH-1:0]   s;
    logic [WIDTH-1:0]   stable_q;
    logic [WIDTH-1:0]   stable_d_q;
    logic [WIDTH-1:0]   stable_next;
    logic [WIDTH-1:0]   irq_q;
    logic [WIDTH-1:0]   glitch;
    logic [DB_BITS-1:0] cnt_q    [WIDTH];
    logic [DB_BITS-1:0] cnt_next [WIDTH];

    // Polarity is folded in ahead of the first flop so reset state always reads as inactive.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= irq_raw_i ^ polarity_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[STAGES-1];

    always_comb begin
        stable_next = stable_q;
        glitch      = '0;
        for (int n = 0; n < WIDTH; n++) begin
            cnt_next[n] = cnt_q[n];
            if (s[n] == stable_q[n]) begin
                if (cnt_q[n] != '0) begin
                    cnt_next[n] = '0;
                    glitch[n]   = 1'b1;
                end
            end else if (cnt_q[n] >= debounce_len_i) begin
                stable_next[n] = s[n];
                cnt_next[n]    = '0;
            end else if (cnt_q[n] != '1) begin
                cnt_next[n] = cnt_q[n] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int n = 0; n < WIDTH; n++) begin
                cnt_q[n] <= '0;
            end
            stable_q   <= '0;
            stable_d_q <= '0;
            irq_q      <= '0;
        end else begin
            for (int n = 0; n < WIDTH; n++) begin
                cnt_q[n] <= cnt_next[n];
            end
            stable_q   <= stable_next;
            stable_d_q <= stable_q;
            // Mode only selects the term; switching it alone cannot produce a pulse.
            irq_q      <= (edge_mode_i & stable_q & ~stable_d_q) | (~edge_mode_i & stable_q);
        end
    end

    assign irq_o    = irq_q;
    assign stable_o = stable_q;

`ifdef IRQ_GLITCH_CNT_EN
    logic [7:0] glitch_cnt_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            glitch_cnt_q <= 8'h00;
        end else if (glitch_cnt_clr_i) begin
            glitch_cnt_q <= 8'h00;
        end else if ((|glitch) && (glitch_cnt_q != 8'hff)) begin
            glitch_cnt_q <= glitch_cnt_q + 8'h01;
        end
    end

    assign glitch_cnt_o = glitch_cnt_q;
`else
    logic unused_glitch;

    assign unused_glitch = ^{glitch_cnt_clr_i, glitch};
    assign glitch_cnt_o  = 8'h00;
`endif

endmodule
